// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver with majority-vote mid-bit sampling.
// Optional parity support is enabled by defining UART_RX_PARITY_EN.
module uart_rx_param #(
    parameter int DATA_W      = 8,
    parameter int OVS         = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Tick,
    input  logic              RxEn,
    input  logic              Rx,
    input  logic [3:0]        NBits,
    input  logic              StopBits,
`ifdef UART_RX_PARITY_EN
    input  logic              ParityEn,
    input  logic              ParityOdd,
    output logic              ParityErr,
`endif
    output logic [DATA_W-1:0] RxData,
    output logic              RxDone,
    output logic              FrameErr,
    output logic              BreakDet
);

    localparam int TW = $clog2(OVS);
    localparam logic [TW-1:0] C_MID_LO = TW'(OVS/2 - 1);
    localparam logic [TW-1:0] C_MID    = TW'(OVS/2);
    localparam logic [TW-1:0] C_MID_HI = TW'(OVS/2 + 1);
    localparam logic [TW-1:0] C_LAST   = TW'(OVS - 1);
    localparam logic [3:0]    C_DW     = 4'(DATA_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_WAIT
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [TW-1:0]         r_tcnt;
    logic                  r_s0;
    logic                  r_s1;
    logic                  r_vote;
    logic [3:0]            r_bitIdx;
    logic [3:0]            r_nBits;
    logic                  r_twoStop;
    logic                  r_stopIdx;
    logic                  r_stopBad;
    logic [DATA_W-1:0]     r_shift;
    logic [DATA_W-1:0]     r_rxData;
    logic                  r_rxDone;
    logic                  r_frameErr;
    logic                  r_break;
    logic                  w_rxs;
    logic                  w_vote;
    logic                  w_mid;
    logic                  w_wrap;
    logic                  w_lastStop;
    logic                  w_finish;
    logic                  w_confirm;
    logic                  w_dataShift;
    logic                  w_badFrame;
    logic [3:0]            w_nClamp;
`ifdef UART_RX_PARITY_EN
    logic                  r_parEn;
    logic                  r_parOdd;
    logic                  r_parAcc;
    logic                  r_parityErr;
`endif

    assign w_rxs    = r_sync[SYNC_STAGES-1];
    assign w_mid    = Tick && (r_tcnt == C_MID_HI);
    assign w_wrap   = Tick && (r_tcnt == C_LAST);
    assign w_vote   = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);
    assign w_nClamp = (NBits < 4'd5) ? 4'd5 : ((NBits > C_DW) ? C_DW : NBits);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (!RxEn) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (Tick && !w_rxs) w_next = S_START;
                S_START: if (w_wrap) w_next = r_vote ? S_IDLE : S_DATA;
                S_DATA: begin
                    if (w_wrap && (r_bitIdx == r_nBits - 4'd1)) begin
`ifdef UART_RX_PARITY_EN
                        w_next = r_parEn ? S_PARITY : S_STOP;
`else
                        w_next = S_STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: if (w_wrap) w_next = S_STOP;
`endif
                S_STOP:  if (w_finish) w_next = w_rxs ? S_IDLE : S_WAIT;
                S_WAIT:  if (Tick && w_rxs) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // The frame closes at the middle of the last stop bit so the next start edge is never missed.
    always_comb begin
        w_confirm   = 1'b0;
        w_dataShift = 1'b0;
        w_lastStop  = 1'b0;
        w_finish    = 1'b0;
        w_badFrame  = 1'b0;
        case (r_state)
            S_START: w_confirm   = w_wrap && !r_vote;
            S_DATA:  w_dataShift = w_wrap;
            S_STOP: begin
                w_lastStop = (r_stopIdx == r_twoStop);
                w_finish   = w_lastStop && w_mid;
                w_badFrame = r_stopBad | ~w_vote;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_sync     <= '1;
            r_tcnt     <= '0;
            r_s0       <= 1'b1;
            r_s1       <= 1'b1;
            r_vote     <= 1'b1;
            r_bitIdx   <= '0;
            r_nBits    <= 4'd8;
            r_twoStop  <= 1'b0;
            r_stopIdx  <= 1'b0;
            r_stopBad  <= 1'b0;
            r_shift    <= '0;
            r_rxData   <= '0;
            r_rxDone   <= 1'b0;
            r_frameErr <= 1'b0;
            r_break    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parEn     <= 1'b0;
            r_parOdd    <= 1'b0;
            r_parAcc    <= 1'b0;
            r_parityErr <= 1'b0;
`endif
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], Rx};
            r_rxDone   <= 1'b0;
            r_frameErr <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_parityErr <= 1'b0;
`endif
            if (!RxEn) begin
                r_tcnt    <= '0;
                r_bitIdx  <= '0;
                r_stopIdx <= 1'b0;
                r_stopBad <= 1'b0;
                r_break   <= 1'b0;
            end else begin
                if (r_state == S_IDLE || w_next == S_IDLE || w_next == S_WAIT) begin
                    r_tcnt <= '0;
                end else if (Tick) begin
                    r_tcnt <= (r_tcnt == C_LAST) ? '0 : r_tcnt + TW'(1);
                end

                if (Tick && r_tcnt == C_MID_LO) r_s0 <= w_rxs;
                if (Tick && r_tcnt == C_MID)    r_s1 <= w_rxs;
                if (w_mid)                      r_vote <= w_vote;

                if (w_confirm) begin
                    r_nBits   <= w_nClamp;
                    r_twoStop <= StopBits;
                    r_bitIdx  <= '0;
                    r_stopIdx <= 1'b0;
                    r_stopBad <= 1'b0;
                    r_shift   <= '0;
`ifdef UART_RX_PARITY_EN
                    r_parEn  <= ParityEn;
                    r_parOdd <= ParityOdd;
                    r_parAcc <= 1'b0;
`endif
                end

                if (w_dataShift) begin
                    r_shift  <= r_shift | (DATA_W'(r_vote) << r_bitIdx);
                    r_bitIdx <= r_bitIdx + 4'd1;
`ifdef UART_RX_PARITY_EN
                    r_parAcc <= r_parAcc ^ r_vote;
`endif
                end

`ifdef UART_RX_PARITY_EN
                if (r_state == S_PARITY && w_wrap) r_parAcc <= r_parAcc ^ r_vote;
`endif

                if (r_state == S_STOP && w_mid)                   r_stopBad <= r_stopBad | ~w_vote;
                if (r_state == S_STOP && w_wrap && !w_lastStop)   r_stopIdx <= 1'b1;

                if (w_finish) begin
                    r_rxData   <= r_shift;
                    r_rxDone   <= 1'b1;
                    r_frameErr <= w_badFrame;
`ifdef UART_RX_PARITY_EN
                    r_parityErr <= r_parEn && (r_parAcc != r_parOdd);
`endif
                end

                if (w_finish && w_badFrame && (r_shift == '0)) begin
                    r_break <= 1'b1;
                end else if (w_rxs) begin
                    r_break <= 1'b0;
                end
            end
        end
    end

    assign RxData   = r_rxData;
    assign RxDone   = r_rxDone;
    assign FrameErr = r_frameErr;
    assign BreakDet = r_break;
`ifdef UART_RX_PARITY_EN
    assign ParityErr = r_parityErr;
`endif

endmodule
